// File: rtl/dff_response_checker_if.sv
// ---------------------------------------------------------------------------
// dff_response_checker_if
// Bundles the signals between a D flip-flop under observation and its
// on-chip response checker.
//   start          run request (one cycle)
//   dut_rst_n      observed reset of the flip-flop under test
//   D, Q           observed data input / output of the flip-flop under test
//   busy, done     run in progress / run complete (held until next start)
//   pass           valid with done; no mismatches in the run
//   err_pulse      one-cycle strobe per mismatch
//   err_cnt        saturating mismatch count
//   pat_cnt        compares performed this run
//   first_err_idx  pat_cnt value at the first mismatch
// The master modport belongs to the environment that drives the observed
// signals. The slave modport belongs to the checker.
// ---------------------------------------------------------------------------
interface dff_response_checker_if #(
   parameter int CNT_W = 8,
   parameter int ERR_W = 8
);
   logic             start;
   logic             dut_rst_n;
   logic             D;
   logic             Q;
   logic             busy;
   logic             done;
   logic             pass;
   logic             err_pulse;
   logic [ERR_W-1:0] err_cnt;
   logic [CNT_W-1:0] pat_cnt;
   logic [CNT_W-1:0] first_err_idx;

   modport master (
      output start, dut_rst_n, D, Q,
      input  busy, done, pass, err_pulse, err_cnt, pat_cnt, first_err_idx
   );

   modport slave (
      input  start, dut_rst_n, D, Q,
      output busy, done, pass, err_pulse, err_cnt, pat_cnt, first_err_idx
   );
endinterface

// File: rtl/dff_response_checker.sv
// ---------------------------------------------------------------------------
// dff_response_checker
// Hardware response checker for a single async-reset D flip-flop. It keeps a
// cycle-accurate model of the expected Q. It compares the observed Q with
// that model on PATNUM consecutive clock edges after a start request. It
// counts the compares and the mismatches.
// Ports:
//   clk    checker clock, shared with the flip-flop under test (rising edge)
//   rst_n  asynchronous active-low checker reset
//   mon    dff_response_checker_if.slave: start, observed dut_rst_n/D/Q in;
//          busy/done/pass/err_pulse/err_cnt/pat_cnt/first_err_idx out
// All outputs are driven directly from flops.
// ---------------------------------------------------------------------------
module dff_response_checker #(
   parameter int PATNUM = 100,
   parameter int CNT_W  = 8,
   parameter int ERR_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   dff_response_checker_if.slave  mon
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PATNUM - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
   localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   state_t           state_q, state_d;
   logic             exp_q, exp_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
   logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;

   logic             exp_now_s;
   logic             mismatch_s;

   // Expected Q at this edge and the compare result. The async clear of the
   // flip-flop under test is already visible at the sampling edge.
   always_comb begin
      exp_now_s  = mon.dut_rst_n ? exp_q : 1'b0;
      mismatch_s = (mon.Q != exp_now_s);
   end

   // Next-state, counter and output logic.
   always_comb begin
      state_d         = state_q;
      exp_d           = mon.dut_rst_n ? mon.D : 1'b0;  // model tracks every edge
      err_pulse_d     = 1'b0;
      err_cnt_d       = err_cnt_q;
      pat_cnt_d       = pat_cnt_q;
      first_err_idx_d = first_err_idx_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (mon.start) begin
               state_d         = S_ARM;
               err_cnt_d       = ERR_ZERO;
               pat_cnt_d       = CNT_ZERO;
               first_err_idx_d = CNT_ZERO;
            end else begin
               state_d = state_q;
            end
         end
         // The model primes from the live D here. No compare is made.
         S_ARM: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            pat_cnt_d = pat_cnt_q + CNT_ONE;
            if (mismatch_s) begin
               err_pulse_d = 1'b1;
               if (err_cnt_q != ERR_MAX) begin
                  err_cnt_d = err_cnt_q + ERR_ONE;
               end else begin
                  err_cnt_d = err_cnt_q;
               end
               if (err_cnt_q == ERR_ZERO) begin
                  first_err_idx_d = pat_cnt_q;
               end else begin
                  first_err_idx_d = first_err_idx_q;
               end
            end else begin
               err_pulse_d = 1'b0;
            end
            if (pat_cnt_q == PAT_LAST) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CHECK;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_ARM) || (state_d == S_CHECK);
      done_d = (state_d == S_DONE);
      pass_d = done_d && (err_cnt_d == ERR_ZERO);
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         exp_q           <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         err_pulse_q     <= 1'b0;
         err_cnt_q       <= ERR_ZERO;
         pat_cnt_q       <= CNT_ZERO;
         first_err_idx_q <= CNT_ZERO;
      end else begin
         state_q         <= state_d;
         exp_q           <= exp_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         pass_q          <= pass_d;
         err_pulse_q     <= err_pulse_d;
         err_cnt_q       <= err_cnt_d;
         pat_cnt_q       <= pat_cnt_d;
         first_err_idx_q <= first_err_idx_d;
      end
   end

   assign mon.busy          = busy_q;
   assign mon.done          = done_q;
   assign mon.pass          = pass_q;
   assign mon.err_pulse     = err_pulse_q;
   assign mon.err_cnt       = err_cnt_q;
   assign mon.pat_cnt       = pat_cnt_q;
   assign mon.first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// ---------------------------------------------------------------------------
// tb_dff_response_checker
// Drives an ideal async-reset flip-flop model into two checker instances:
//   A: PATNUM=100, CNT_W=8, ERR_W=8
//   B: PATNUM=300, CNT_W=9, ERR_W=8
// It can flip or stick the observed Q. The expected err_pulse of each compare
// is queued when its stimulus is driven. It is popped when the result appears.
// ---------------------------------------------------------------------------
module tb_dff_response_checker;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic d_s, dut_rst_n_s, start_a, start_b, flip_a, stuck_a;
   logic dff_q;

   int   n_chk  = 0;
   int   n_fail = 0;
   bit   sb[$];

   dff_response_checker_if #(.CNT_W(8), .ERR_W(8)) ifa ();
   dff_response_checker_if #(.CNT_W(9), .ERR_W(8)) ifb ();

   dff_response_checker #(.PATNUM(100), .CNT_W(8), .ERR_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .mon(ifa));
   dff_response_checker #(.PATNUM(300), .CNT_W(9), .ERR_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .mon(ifb));

   // Ideal flip-flop under test.
   always_ff @(posedge clk or negedge dut_rst_n_s) begin
      if (!dut_rst_n_s) dff_q <= 1'b0;
      else              dff_q <= d_s;
   end

   assign ifa.D         = d_s;
   assign ifa.dut_rst_n = dut_rst_n_s;
   assign ifa.start     = start_a;
   assign ifa.Q         = stuck_a ? 1'b1 : (flip_a ? ~dff_q : dff_q);
   assign ifb.D         = d_s;
   assign ifb.dut_rst_n = dut_rst_n_s;
   assign ifb.start     = start_b;
   assign ifb.Q         = 1'b1;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic read_outs(input bit sel, output int busy, output int done,
                            output int pass, output int ep, output int ec,
                            output int pc, output int fe);
      if (sel) begin
         busy = int'(ifb.busy); done = int'(ifb.done); pass = int'(ifb.pass);
         ep = int'(ifb.err_pulse); ec = int'(ifb.err_cnt);
         pc = int'(ifb.pat_cnt); fe = int'(ifb.first_err_idx);
      end else begin
         busy = int'(ifa.busy); done = int'(ifa.done); pass = int'(ifa.pass);
         ep = int'(ifa.err_pulse); ec = int'(ifa.err_cnt);
         pc = int'(ifa.pat_cnt); fe = int'(ifa.first_err_idx);
      end
   endtask

   task automatic check_all_zero(input bit sel, input string tag);
      int busy, done, pass, ep, ec, pc, fe;
      read_outs(sel, busy, done, pass, ep, ec, pc, fe);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_pass"}, pass, 0);
      check_val({tag, "_err_pulse"}, ep, 0);
      check_val({tag, "_err_cnt"}, ec, 0);
      check_val({tag, "_pat_cnt"}, pc, 0);
      check_val({tag, "_first_err"}, fe, 0);
   endtask

   // One run. A negative index disables the corresponding event.
   task automatic run_one(input bit sel, input int n, input int flip_idx,
                          input int rlo, input int rhi, input bit stuck_rst,
                          input int restart_idx, input int abort_idx,
                          input bit d_zero);
      int  busy, done, pass, ep, ec, pc, fe;
      int  exp_err   = 0;
      int  exp_first = 0;
      bit  seen      = 1'b0;
      bit  exp_m;
      bit  in_rst;
      sb.delete();

      @(negedge clk);
      d_s = d_zero ? 1'b0 : 1'($urandom);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      read_outs(sel, busy, done, pass, ep, ec, pc, fe);
      check_val("start_busy", busy, 1);
      check_val("start_done", done, 0);
      check_val("start_pat_cnt", pc, 0);
      check_val("start_err_cnt", ec, 0);
      check_val("start_first_err", fe, 0);

      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      d_s = d_zero ? 1'b0 : 1'($urandom);
      @(posedge clk); #1;                      // ARM edge: no compare
      read_outs(sel, busy, done, pass, ep, ec, pc, fe);
      check_val("arm_err_pulse", ep, 0);
      check_val("arm_pat_cnt", pc, 0);

      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k == abort_idx) begin
            #1 rst_n = 1'b0;
            #1 check_all_zero(sel, "abort");
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
            read_outs(sel, busy, done, pass, ep, ec, pc, fe);
            check_val("post_abort_done", done, 0);
            check_val("post_abort_busy", busy, 0);
            sb.delete();
            return;
         end
         in_rst      = (k >= rlo) && (k <= rhi);
         dut_rst_n_s = !in_rst;
         d_s         = d_zero ? 1'b0 : (in_rst ? 1'b1 : 1'($urandom));
         flip_a      = (k == flip_idx);
         stuck_a     = stuck_rst && in_rst;
         if (sel) start_b = (k == restart_idx); else start_a = (k == restart_idx);
         #1;
         exp_m = sel ? (ifb.Q != dff_q) : (ifa.Q != dff_q);
         sb.push_back(exp_m);
         if (exp_m) begin
            if (!seen) exp_first = k;
            seen = 1'b1;
            if (exp_err < 255) exp_err++;
         end
         @(posedge clk); #1;
         read_outs(sel, busy, done, pass, ep, ec, pc, fe);
         check_val("err_pulse", ep, int'(sb.pop_front()));
         check_val("pat_cnt", pc, k + 1);
         if (k == n - 2) begin
            check_val("pre_done_busy", busy, 1);
            check_val("pre_done_done", done, 0);
         end
      end

      @(negedge clk);
      flip_a = 1'b0; stuck_a = 1'b0; dut_rst_n_s = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      read_outs(sel, busy, done, pass, ep, ec, pc, fe);
      check_val("end_done", done, 1);
      check_val("end_busy", busy, 0);
      check_val("end_pass", pass, (exp_err == 0) ? 1 : 0);
      check_val("end_err_cnt", ec, exp_err);
      check_val("end_pat_cnt", pc, n);
      check_val("end_first_err", fe, exp_first);
      @(posedge clk); #1;
      read_outs(sel, busy, done, pass, ep, ec, pc, fe);
      check_val("hold_done", done, 1);
      check_val("hold_err_pulse", ep, 0);
      check_val("hold_pat_cnt", pc, n);
      check_val("hold_err_cnt", ec, exp_err);
   endtask

   initial begin
      rst_n = 1'b0; dut_rst_n_s = 1'b0; d_s = 1'b0;
      start_a = 1'b0; start_b = 1'b0; flip_a = 1'b0; stuck_a = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero(1'b0, "reset_a");
      check_all_zero(1'b1, "reset_b");
      rst_n = 1'b1; dut_rst_n_s = 1'b1;
      repeat (2) @(negedge clk);

      run_one(1'b0, 100, -1, -1, -1, 1'b0, -1, -1, 1'b0);  // clean run
      run_one(1'b0, 100,  5, -1, -1, 1'b0, -1, -1, 1'b0);  // single flip, from DONE
      run_one(1'b0, 100, -1, 10, 14, 1'b0, -1, -1, 1'b0);  // DUT reset window, correct
      run_one(1'b0, 100, -1, 10, 14, 1'b1, -1, -1, 1'b0);  // DUT reset window, Q stuck
      run_one(1'b0, 100, -1, -1, -1, 1'b0, 40, -1, 1'b0);  // start while busy
      run_one(1'b0, 100, -1, -1, -1, 1'b0, -1, 50, 1'b0);  // checker reset mid-run
      run_one(1'b0, 100, -1, -1, -1, 1'b0, -1, -1, 1'b0);  // fresh run after abort
      run_one(1'b1, 300, -1, -1, -1, 1'b0, -1, -1, 1'b1);  // saturation

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
